// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forward-select codes and Tuse/Tnew field sizing.
package hazard_pkg;

    localparam int T_W = 3;
    localparam logic [T_W-1:0] TUSE_NONE = 3'd3;

    typedef enum logic [1:0] {
        FWD_GRF = 2'b00,
        FWD_E   = 2'b01,
        FWD_M   = 2'b10,
        FWD_W   = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage tracker: destination register plus cycles remaining until its result exists.
module hazard_stage_reg #(
    parameter int RA_W = 5,
    parameter int T_W  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bubble,
    input  logic [RA_W-1:0] waddr_in,
    input  logic [T_W-1:0]  tnew_in,
    output logic [RA_W-1:0] waddr,
    output logic [T_W-1:0]  tnew
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waddr <= '0;
            tnew  <= '0;
        end else if (bubble) begin
            waddr <= '0;
            tnew  <= '0;
        end else begin
            waddr <= waddr_in;
            tnew  <= (tnew_in == '0) ? '0 : tnew_in - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage hazard detection: stall generation, forward-select priority for D/E/M
// consumers, and a saturating count of stalled cycles.
module hazard_unit #(
    parameter int RA_W  = 5,
    parameter int T_W   = hazard_pkg::T_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [T_W-1:0]   Tuse_rs,
    input  logic [T_W-1:0]   Tuse_rt,
    input  logic [T_W-1:0]   Tnew_D,
    input  logic [RA_W-1:0]  rs_D,
    input  logic [RA_W-1:0]  rt_D,
    input  logic [RA_W-1:0]  waddr_D,
    input  logic             regwrite_D,
    input  logic [RA_W-1:0]  rs_E,
    input  logic [RA_W-1:0]  rt_E,
    input  logic [RA_W-1:0]  rt_M,
    output logic             stall,
    output logic [1:0]       fwd_rs_D,
    output logic [1:0]       fwd_rt_D,
    output logic [1:0]       fwd_rs_E,
    output logic [1:0]       fwd_rt_E,
    output logic             fwd_rt_M,
    output logic [CNT_W-1:0] stall_cnt
);
    import hazard_pkg::*;

    logic [RA_W-1:0] waddr_e, waddr_m, waddr_w;
    logic [T_W-1:0]  tnew_e, tnew_m, tnew_w;

    hazard_stage_reg #(.RA_W(RA_W), .T_W(T_W)) u_stage_e (
        .clk(clk), .reset(reset), .bubble(stall),
        .waddr_in(regwrite_D ? waddr_D : '0), .tnew_in(Tnew_D),
        .waddr(waddr_e), .tnew(tnew_e)
    );

    hazard_stage_reg #(.RA_W(RA_W), .T_W(T_W)) u_stage_m (
        .clk(clk), .reset(reset), .bubble(1'b0),
        .waddr_in(waddr_e), .tnew_in(tnew_e),
        .waddr(waddr_m), .tnew(tnew_m)
    );

    // Feeding zero makes the W entry always ready, whatever M held.
    hazard_stage_reg #(.RA_W(RA_W), .T_W(T_W)) u_stage_w (
        .clk(clk), .reset(reset), .bubble(1'b0),
        .waddr_in(waddr_m), .tnew_in('0),
        .waddr(waddr_w), .tnew(tnew_w)
    );

    function automatic logic needs_stall(input logic [RA_W-1:0] src, input logic [T_W-1:0] tuse);
        return (src != '0) &&
               (((src == waddr_e) && (tuse < tnew_e)) ||
                ((src == waddr_m) && (tuse < tnew_m)));
    endfunction

    // Only the youngest matching stage counts; if it is not ready yet we fall back to
    // the register/pipe value rather than an older, stale copy.
    function automatic fwd_sel_e pick(input logic [RA_W-1:0] src, input logic see_e,
                                      input logic see_m);
        fwd_sel_e sel;
        sel = FWD_GRF;
        if (src == '0)
            sel = FWD_GRF;
        else if (see_e && (src == waddr_e))
            sel = (tnew_e == '0) ? FWD_E : FWD_GRF;
        else if (see_m && (src == waddr_m))
            sel = (tnew_m == '0) ? FWD_M : FWD_GRF;
        else if (src == waddr_w)
            sel = (tnew_w == '0) ? FWD_W : FWD_GRF;
        return sel;
    endfunction

    assign stall    = needs_stall(rs_D, Tuse_rs) | needs_stall(rt_D, Tuse_rt);
    assign fwd_rs_D = pick(rs_D, 1'b1, 1'b1);
    assign fwd_rt_D = pick(rt_D, 1'b1, 1'b1);
    assign fwd_rs_E = pick(rs_E, 1'b0, 1'b1);
    assign fwd_rt_E = pick(rt_E, 1'b0, 1'b1);
    assign fwd_rt_M = (pick(rt_M, 1'b0, 1'b0) == FWD_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed hazard scenarios then random instruction streams,
// checked against an age-indexed pipeline model using absolute result-ready times.
module tb_hazard_unit;

    localparam int RA_W  = 5;
    localparam int T_W   = 3;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [T_W-1:0]   Tuse_rs, Tuse_rt, Tnew_D;
    logic [RA_W-1:0]  rs_D, rt_D, waddr_D, rs_E, rt_E, rt_M;
    logic             regwrite_D;
    logic             stall, fwd_rt_M;
    logic [1:0]       fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic [CNT_W-1:0] stall_cnt;

    hazard_unit #(.RA_W(RA_W), .T_W(T_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .Tnew_D(Tnew_D),
        .rs_D(rs_D), .rt_D(rt_D), .waddr_D(waddr_D), .regwrite_D(regwrite_D),
        .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
        .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs; int rt; int tuse_rs; int tuse_rt; int tnew; int waddr; bit rw;
    } instr_t;

    // ready = absolute cycle at which the result exists; age 1=E, 2=M, 3=W
    typedef struct {
        int rs; int rt; int tuse_rs; int tuse_rt; int dest; int ready;
    } ent_t;

    ent_t   pipe [1:3];
    int     cyc, exp_cnt, vectors, miscompares;
    bit     m_stall;
    instr_t cur;

    function automatic instr_t mk(input int rs, input int rt, input int tu_rs, input int tu_rt,
                                  input int tnew, input int waddr, input bit rw);
        instr_t i;
        i.rs = rs; i.rt = rt; i.tuse_rs = tu_rs; i.tuse_rt = tu_rt;
        i.tnew = tnew; i.waddr = waddr; i.rw = rw;
        return i;
    endfunction

    function automatic ent_t empty_ent();
        ent_t e;
        e.rs = 0; e.rt = 0; e.tuse_rs = 3; e.tuse_rt = 3; e.dest = 0; e.ready = 0;
        return e;
    endfunction

    function automatic int tnew_of(input int a);
        int t;
        t = pipe[a].ready - cyc;
        return (t > 0) ? t : 0;
    endfunction

    function automatic int nearest(input int src, input int first);
        for (int a = first; a <= 3; a++)
            if (src != 0 && pipe[a].dest == src) return a;
        return 0;
    endfunction

    // Select code numerically equals the producer's age (E=1, M=2, W=3).
    function automatic int exp_fwd(input int src, input int first);
        int a;
        a = nearest(src, first);
        return (a != 0 && tnew_of(a) == 0) ? a : 0;
    endfunction

    function automatic bit exp_stall_of(input int src, input int tuse);
        for (int a = 1; a <= 2; a++)
            if (src != 0 && pipe[a].dest == src && tuse < tnew_of(a)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_model();
        for (int a = 1; a <= 3; a++) pipe[a] = empty_ent();
        cyc = 0;
        exp_cnt = 0;
        m_stall = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic present(input instr_t ins);
        cur        = ins;
        Tuse_rs    = T_W'(ins.tuse_rs);
        Tuse_rt    = T_W'(ins.tuse_rt);
        Tnew_D     = T_W'(ins.tnew);
        rs_D       = RA_W'(ins.rs);
        rt_D       = RA_W'(ins.rt);
        waddr_D    = RA_W'(ins.waddr);
        regwrite_D = ins.rw;
        rs_E       = RA_W'(pipe[1].rs);
        rt_E       = RA_W'(pipe[1].rt);
        rt_M       = RA_W'(pipe[2].rt);
        #3;
        m_stall = exp_stall_of(ins.rs, ins.tuse_rs) || exp_stall_of(ins.rt, ins.tuse_rt);
        chk("stall",     64'(stall),     64'(m_stall));
        chk("fwd_rs_D",  64'(fwd_rs_D),  64'(exp_fwd(ins.rs, 1)));
        chk("fwd_rt_D",  64'(fwd_rt_D),  64'(exp_fwd(ins.rt, 1)));
        chk("fwd_rs_E",  64'(fwd_rs_E),  64'(exp_fwd(pipe[1].rs, 2)));
        chk("fwd_rt_E",  64'(fwd_rt_E),  64'(exp_fwd(pipe[1].rt, 2)));
        chk("fwd_rt_M",  64'(fwd_rt_M),  64'(exp_fwd(pipe[2].rt, 3) == 3));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
        // An operand consumed in E must find its nearest producer already complete.
        if (pipe[1].tuse_rs <= 1 && nearest(pipe[1].rs, 2) != 0)
            chk("legal_rs_E", 64'(fwd_rs_E), 64'(nearest(pipe[1].rs, 2)));
        if (pipe[1].tuse_rt <= 1 && nearest(pipe[1].rt, 2) != 0)
            chk("legal_rt_E", 64'(fwd_rt_E), 64'(nearest(pipe[1].rt, 2)));
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_stall) exp_cnt++;
        pipe[3] = pipe[2];
        pipe[2] = pipe[1];
        if (m_stall) begin
            pipe[1] = empty_ent();
        end else begin
            pipe[1].rs      = cur.rs;
            pipe[1].rt      = cur.rt;
            pipe[1].tuse_rs = cur.tuse_rs;
            pipe[1].tuse_rt = cur.tuse_rt;
            pipe[1].dest    = cur.rw ? cur.waddr : 0;
            pipe[1].ready   = cyc + cur.tnew;
        end
        cyc++;
        #1;
    endtask

    // Hold the instruction in D until the model releases it; report stall cycles and
    // the D-stage rs select seen on the issuing cycle.
    task automatic issue(input instr_t ins, output int nst, output logic [1:0] f);
        nst = 0;
        f   = 2'b00;
        for (int i = 0; i < 6; i++) begin
            present(ins);
            f = fwd_rs_D;
            if (!m_stall) begin
                advance();
                return;
            end
            advance();
            nst++;
        end
        vectors++;
        miscompares++;
        $error("FAIL issue_timeout: stalled %0d cycles, required release within 5", nst);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
    endtask

    instr_t nop, ins;
    int     n;
    logic [1:0] f;

    initial begin
        vectors = 0;
        miscompares = 0;
        nop = mk(0, 0, 3, 3, 0, 0, 1'b0);
        clear_model();
        reset = 1'b1;
        Tuse_rs = '0; Tuse_rt = '0; Tnew_D = '0; rs_D = '0; rt_D = '0; waddr_D = '0;
        regwrite_D = 1'b0; rs_E = '0; rt_E = '0; rt_M = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        present(nop);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        advance();

        // load-use: lw $8 then add using $8 in E
        do_reset();
        issue(mk(1, 8, 1, 3, 3, 8, 1'b1), n, f);
        issue(mk(8, 9, 1, 1, 2, 10, 1'b1), n, f);
        chk("s1_width", 64'(n), 64'd1);
        chk("s1_fwd_rs_D", 64'(f), 64'd0);
        chk("s1_cnt", 64'(stall_cnt), 64'd1);
        present(nop);
        chk("s1_fwd_rs_E", 64'(fwd_rs_E), 64'd3);
        advance();

        // ALU result to branch compare in D
        do_reset();
        issue(mk(1, 2, 1, 1, 2, 5, 1'b1), n, f);
        issue(mk(5, 0, 0, 3, 0, 0, 1'b0), n, f);
        chk("s2_width", 64'(n), 64'd1);
        chk("s2_fwd_rs_D", 64'(f), 64'd2);
        chk("s2_cnt", 64'(stall_cnt), 64'd1);

        // jal then jr $31
        do_reset();
        issue(mk(0, 0, 3, 3, 0, 31, 1'b1), n, f);
        issue(mk(31, 0, 0, 3, 0, 0, 1'b0), n, f);
        chk("s3_width", 64'(n), 64'd0);
        chk("s3_fwd_rs_D", 64'(f), 64'd1);

        // back-to-back writers of $3: nearest wins, never the older W copy
        do_reset();
        issue(mk(1, 2, 1, 1, 2, 3, 1'b1), n, f);
        issue(mk(3, 3, 1, 1, 2, 3, 1'b1), n, f);
        chk("s4_width", 64'(n), 64'd0);
        present(mk(3, 0, 1, 3, 2, 4, 1'b1));
        chk("s4_fwd_rs_E_a", 64'(fwd_rs_E), 64'd2);
        advance();
        present(nop);
        chk("s4_fwd_rs_E_b", 64'(fwd_rs_E), 64'd2);
        advance();

        // writes to $0 are invisible
        do_reset();
        issue(mk(1, 2, 1, 1, 2, 0, 1'b1), n, f);
        issue(mk(0, 0, 0, 0, 0, 0, 1'b0), n, f);
        chk("s5_width", 64'(n), 64'd0);
        chk("s5_fwd_rs_D", 64'(f), 64'd0);

        // reset asserted mid-stall, then an unused operand matching a pending load
        do_reset();
        issue(mk(1, 8, 1, 3, 3, 8, 1'b1), n, f);
        present(mk(8, 0, 1, 3, 2, 10, 1'b1));
        chk("s6_stall_pre", 64'(stall), 64'd1);
        reset = 1'b1;
        #1;
        chk("s6_stall_rst", 64'(stall), 64'd0);
        chk("s6_fwd_rs_D_rst", 64'(fwd_rs_D), 64'd0);
        chk("s6_fwd_rs_E_rst", 64'(fwd_rs_E), 64'd0);
        chk("s6_cnt_rst", 64'(stall_cnt), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        issue(mk(0, 9, 3, 3, 3, 9, 1'b1), n, f);
        issue(mk(9, 9, 3, 3, 1, 11, 1'b1), n, f);
        chk("s6_tuse_none", 64'(n), 64'd0);

        // random streams over a small register window to force frequent matches
        do_reset();
        for (int k = 0; k < 400; k++) begin
            ins = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)));
            issue(ins, n, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
